// File: rtl/cg_alu_pkg.sv
// Shared CG ALU definitions: default element geometry, row-word width and the
// unsigned max helper used for high-water count tracking.
package cg_alu_pkg;

  localparam int CG_ELEMENT_WIDTH = 32;
  localparam int CG_NO_OF_UNITS   = 8;
  localparam int CG_WORD_W        = CG_ELEMENT_WIDTH * CG_NO_OF_UNITS;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rk_prev_bank.sv
// Simple dual-port row RAM for one residual bank: one write port, one read port,
// registered read data that holds its value between reads.
module rk_prev_bank #(
  parameter int W          = 256,
  parameter int DEPTH      = 1024,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [W-1:0]          i_wdata,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [W-1:0]          o_rdata
);

  logic [W-1:0] r_mem [DEPTH];
  logic [W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/rk_prev_pingpong_bank.sv
// Ping-pong store of the previous-iteration residual r_k: the write bank collects
// the current iteration while the read bank serves the previous one; swap exchanges them.
module rk_prev_pingpong_bank
  import cg_alu_pkg::*;
#(
  parameter int ELEMENT_WIDTH = CG_ELEMENT_WIDTH,
  parameter int NO_OF_UNITS   = CG_NO_OF_UNITS,
  parameter int ADDR_WIDTH    = 10,
  parameter int DEPTH         = 1024,
  parameter int READ_LATENCY  = 1,
  localparam int W            = ELEMENT_WIDTH * NO_OF_UNITS,
  localparam int CW           = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [W-1:0]          wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  swap,
  output logic [W-1:0]          rd_data,
  output logic                  rd_valid,
  output logic                  rd_hit,
  output logic [CW-1:0]         wr_count,
  output logic [CW-1:0]         prev_count,
  output logic                  bank_sel,
  output logic                  overflow
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic          r_bank_sel;
  logic [CW-1:0] r_wr_count;
  logic [CW-1:0] r_prev_count;
  logic          r_overflow;

  logic [CW-1:0] w_wr_addr_x;
  logic [CW-1:0] w_rd_addr_x;
  logic          w_wr_ok;
  logic          w_re;
  logic [CW-1:0] w_wr_count_nxt;
  logic [1:0]    w_we;
  logic [W-1:0]  w_bank_rdata [2];

  assign w_wr_addr_x    = {1'b0, wr_addr};
  assign w_rd_addr_x    = {1'b0, rd_addr};
  assign w_wr_ok        = wr_en && (w_wr_addr_x < DEPTH_C);
  assign w_re           = rd_en && (w_rd_addr_x < DEPTH_C);
  assign w_wr_count_nxt = w_wr_ok
                        ? CW'(max_u(int'(r_wr_count), int'(w_wr_addr_x + CW'(1))))
                        : r_wr_count;
  assign w_we[0]        = w_wr_ok && !r_bank_sel;
  assign w_we[1]        = w_wr_ok &&  r_bank_sel;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    rk_prev_bank #(
      .W          (W),
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_bank (
      .clk     (clk),
      .i_we    (w_we[b]),
      .i_waddr (wr_addr),
      .i_wdata (wr_data),
      .i_re    (w_re),
      .i_raddr (rd_addr),
      .o_rdata (w_bank_rdata[b])
    );
  end

  // A same-cycle write is folded into the count handed to the read side on swap.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bank_sel   <= 1'b0;
      r_wr_count   <= '0;
      r_prev_count <= '0;
      r_overflow   <= 1'b0;
    end else begin
      if (wr_en && !w_wr_ok) r_overflow <= 1'b1;
      if (swap) begin
        r_bank_sel   <= ~r_bank_sel;
        r_prev_count <= w_wr_count_nxt;
        r_wr_count   <= '0;
      end else begin
        r_wr_count   <= w_wr_count_nxt;
      end
    end
  end

  // Stage p0: read issue; bank choice and hit are frozen with the request.
  logic         r_vld_p0;
  logic         r_hit_p0;
  logic         r_sel_p0;
  logic [W-1:0] w_rd_word_p0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld_p0 <= 1'b0;
      r_hit_p0 <= 1'b0;
    end else begin
      r_vld_p0 <= rd_en;
      if (rd_en) r_hit_p0 <= (w_rd_addr_x < r_prev_count);
    end
  end

  always_ff @(posedge clk) begin
    if (rd_en) r_sel_p0 <= ~r_bank_sel;
  end

  assign w_rd_word_p0 = r_hit_p0 ? w_bank_rdata[r_sel_p0] : '0;

  // Stage p1: optional output register.
  if (READ_LATENCY == 2) begin : g_lat2
    logic         r_vld_p1;
    logic         r_hit_p1;
    logic [W-1:0] r_rd_data_p1;

    always_ff @(posedge clk) begin
      if (reset) begin
        r_vld_p1     <= 1'b0;
        r_hit_p1     <= 1'b0;
        r_rd_data_p1 <= '0;
      end else begin
        r_vld_p1 <= r_vld_p0;
        if (r_vld_p0) begin
          r_hit_p1     <= r_hit_p0;
          r_rd_data_p1 <= w_rd_word_p0;
        end
      end
    end

    assign rd_valid = r_vld_p1;
    assign rd_hit   = r_hit_p1;
    assign rd_data  = r_rd_data_p1;
  end else begin : g_lat1
    assign rd_valid = r_vld_p0;
    assign rd_hit   = r_hit_p0;
    assign rd_data  = w_rd_word_p0;
  end

  assign wr_count   = r_wr_count;
  assign prev_count = r_prev_count;
  assign bank_sel   = r_bank_sel;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_rk_prev_pingpong_bank.sv
// Directed bench for rk_prev_pingpong_bank: two instances (READ_LATENCY 1 and 2)
// share one stimulus stream; a negedge monitor matches completions against expected reads.
module tb_rk_prev_pingpong_bank;
  import cg_alu_pkg::*;

  localparam int W     = CG_WORD_W;
  localparam int AW    = 10;
  localparam int CW    = AW + 1;
  localparam int DEPTH = 1000;

  typedef struct {
    logic         hit;
    logic [W-1:0] data;
    int           cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset, wr_en, rd_en, swap;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [W-1:0]  wr_data;

  logic [W-1:0]  d1_data, d2_data;
  logic          d1_vld, d2_vld, d1_hit, d2_hit;
  logic [CW-1:0] d1_wc, d2_wc, d1_pc, d2_pc;
  logic          d1_bs, d2_bs, d1_ov, d2_ov;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  exp_t q1[$];
  exp_t q2[$];
  int   run1 = 0, run2 = 0, last1 = 0, last2 = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rk_prev_pingpong_bank #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .READ_LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .swap(swap), .rd_data(d1_data), .rd_valid(d1_vld),
    .rd_hit(d1_hit), .wr_count(d1_wc), .prev_count(d1_pc), .bank_sel(d1_bs), .overflow(d1_ov)
  );

  rk_prev_pingpong_bank #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .READ_LATENCY(2)) u_dut2 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .swap(swap), .rd_data(d2_data), .rd_valid(d2_vld),
    .rd_hit(d2_hit), .wr_count(d2_wc), .prev_count(d2_pc), .bank_sel(d2_bs), .overflow(d2_ov)
  );

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // d doubles as the instance index and its read latency.
  task automatic mon(input int d, input logic vld, input logic hit, input logic [W-1:0] data);
    exp_t e;
    int   n;
    logic due;
    n   = (d == 1) ? q1.size() : q2.size();
    due = 1'b0;
    if (n > 0) begin
      e   = (d == 1) ? q1[0] : q2[0];
      due = ((cyc - e.cyc) == d);
    end
    if (vld || due) begin
      chk($sformatf("d%0d_rd_valid", d), W'(vld), W'(due));
      if (due) begin
        if (d == 1) void'(q1.pop_front()); else void'(q2.pop_front());
        chk($sformatf("d%0d_rd_data", d), data, e.data);
        chk($sformatf("d%0d_rd_hit", d), W'(hit), W'(e.hit));
      end
    end
    if (vld === 1'b1) begin
      if (d == 1) run1++; else run2++;
    end else if (d == 1) begin
      if (run1 != 0) last1 = run1;
      run1 = 0;
    end else begin
      if (run2 != 0) last2 = run2;
      run2 = 0;
    end
    if (reset) begin
      if (d == 1) q1.delete(); else q2.delete();
    end
  endtask

  always @(negedge clk) begin
    mon(1, d1_vld, d1_hit, d1_data);
    mon(2, d2_vld, d2_hit, d2_data);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input int wc, input int pc, input bit bs, input bit ov);
    chk({tag, "_d1_wr_count"},   W'(d1_wc), W'(wc));
    chk({tag, "_d2_wr_count"},   W'(d2_wc), W'(wc));
    chk({tag, "_d1_prev_count"}, W'(d1_pc), W'(pc));
    chk({tag, "_d2_prev_count"}, W'(d2_pc), W'(pc));
    chk({tag, "_d1_bank_sel"},   W'(d1_bs), W'(bs));
    chk({tag, "_d2_bank_sel"},   W'(d2_bs), W'(bs));
    chk({tag, "_d1_overflow"},   W'(d1_ov), W'(ov));
    chk({tag, "_d2_overflow"},   W'(d2_ov), W'(ov));
  endtask

  task automatic wr(input int a, input logic [W-1:0] dat, input bit sw);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = dat; swap = sw;
    tick();
    wr_en = 1'b0; swap = 1'b0;
  endtask

  task automatic do_swap();
    swap = 1'b1;
    tick();
    swap = 1'b0;
  endtask

  task automatic rd(input int a, input bit h, input logic [W-1:0] dat);
    exp_t e;
    rd_en = 1'b1; rd_addr = AW'(a);
    e.hit = h; e.data = dat; e.cyc = cyc;
    q1.push_back(e);
    q2.push_back(e);
    tick();
    rd_en = 1'b0;
  endtask

  task automatic drain(input string tag);
    repeat (4) tick();
    chk({tag, "_d1_pending"}, W'(q1.size()), '0);
    chk({tag, "_d2_pending"}, W'(q2.size()), '0);
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0; swap = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_data = '0;
    repeat (3) tick();
    chk_state("reset", 0, 0, 1'b0, 1'b0);
    chk("reset_d1_rd_valid", W'(d1_vld), '0);
    chk("reset_d2_rd_valid", W'(d2_vld), '0);
    chk("reset_d2_rd_data", d2_data, '0);
    reset = 1'b0;

    // Read straight after reset: miss with zero data.
    rd(0, 1'b0, '0);
    drain("t1");

    // Fill rows 0..4, swap, read 0..5 back to back.
    for (int i = 0; i < 5; i++) wr(i, W'(32'hA0 + i), 1'b0);
    do_swap();
    chk_state("t2", 0, 5, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) rd(i, (i < 5), (i < 5) ? W'(32'hA0 + i) : '0);
    drain("t2");

    // Write coinciding with swap lands in the new read bank.
    wr(7, W'(32'h55), 1'b1);
    chk_state("t3", 0, 8, 1'b0, 1'b0);
    rd(7, 1'b1, W'(32'h55));
    drain("t3");

    // Last legal row, then an out-of-range write.
    wr(999, W'(32'h99), 1'b0);
    chk_state("t4a", 1000, 8, 1'b0, 1'b0);
    wr(1000, W'(32'h77), 1'b0);
    chk_state("t4b", 1000, 8, 1'b0, 1'b1);
    do_swap();
    chk_state("t4c", 0, 1000, 1'b1, 1'b1);
    rd(999, 1'b1, W'(32'h99));
    rd(1000, 1'b0, '0);
    rd(1023, 1'b0, '0);
    drain("t4c");
    swap = 1'b1;
    tick();
    tick();
    swap = 1'b0;
    chk_state("t4d", 0, 0, 1'b1, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_state("t4e", 0, 0, 1'b0, 1'b0);
    do_swap();

    // Burst of 8 with swap on the last issue: every result is pre-swap data.
    for (int i = 0; i < 8; i++) wr(i, W'(32'hB0 + i), 1'b0);
    do_swap();
    for (int i = 0; i < 8; i++) wr(i, W'(32'hC0 + i), 1'b0);
    chk_state("t5a", 8, 8, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      swap = (i == 7);
      rd(i, 1'b1, W'(32'hB0 + i));
    end
    swap = 1'b0;
    drain("t5");
    chk("t5_d1_valid_run", W'(last1), W'(8));
    chk("t5_d2_valid_run", W'(last2), W'(8));
    chk_state("t5b", 0, 8, 1'b1, 1'b0);
    rd(0, 1'b1, W'(32'hC0));
    drain("t5c");

    // Reset in the middle of a burst.
    wr(3, W'(32'hDD), 1'b0);
    for (int i = 0; i < 4; i++) rd(i, 1'b1, W'(32'hC0 + i));
    reset = 1'b1;
    tick();
    chk("t6_d1_rd_valid", W'(d1_vld), '0);
    chk("t6_d2_rd_valid", W'(d2_vld), '0);
    chk("t6_d1_rd_data", d1_data, '0);
    chk("t6_d2_rd_data", d2_data, '0);
    chk_state("t6", 0, 0, 1'b0, 1'b0);
    reset = 1'b0;
    repeat (3) tick();
    rd(0, 1'b0, '0);
    drain("t6");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
